// File: rtl/led_pattern_gen.sv
// LED pattern generator: prescaled stepping through rotate, ping-pong
// and fill-bar patterns, with mode changes applied on the next step tick.
module led_pattern_gen #(
    parameter int LED_NUM = 8,
    parameter int CNT_MAX = 99_999_999,
    parameter int CNT_W   = 27
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic [1:0]         mode_sel,
    input  logic               mode_load,
    input  logic               pause,
    output logic [LED_NUM-1:0] led_out,
    output logic [1:0]         mode_cur,
    output logic               step_pulse,
    output logic               wrap_pulse
);

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CNT_MAX);
    localparam logic [LED_NUM-1:0] PAT_LO   = {{(LED_NUM-1){1'b0}}, 1'b1};
    localparam logic [LED_NUM-1:0] PAT_HI   = {1'b1, {(LED_NUM-1){1'b0}}};

    logic [CNT_W-1:0]   cnt;
    logic               pend;
    logic [1:0]         pend_mode;
    dir_t               dir;
    logic               tick;
    logic [LED_NUM-1:0] nxt_led;
    dir_t               nxt_dir;

    // Starting pattern of each mode; only right-rotate starts at the top.
    function automatic logic [LED_NUM-1:0] init_pat(input logic [1:0] m);
        return (m == 2'd1) ? PAT_HI : PAT_LO;
    endfunction

    assign tick = (cnt == CNT_LAST) && !pause;

    // Next pattern and bounce direction for an ordinary step of the active mode.
    always_comb begin
        nxt_led = led_out;
        nxt_dir = dir;
        unique case (mode_cur)
            2'd0: nxt_led = {led_out[LED_NUM-2:0], led_out[LED_NUM-1]};
            2'd1: nxt_led = {led_out[0], led_out[LED_NUM-1:1]};
            2'd2: begin
                if (dir == DIR_UP) begin
                    if (led_out[LED_NUM-1]) begin
                        nxt_led = led_out >> 1;
                        nxt_dir = DIR_DOWN;
                    end else begin
                        nxt_led = led_out << 1;
                    end
                end else begin
                    if (led_out[0]) begin
                        nxt_led = led_out << 1;
                        nxt_dir = DIR_UP;
                    end else begin
                        nxt_led = led_out >> 1;
                    end
                end
            end
            2'd3: nxt_led = (&led_out) ? PAT_LO
                                       : {led_out[LED_NUM-2:0], 1'b1};
        endcase
    end

    // Prescaler, pending-mode capture and registered pattern outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt        <= '0;
            led_out    <= PAT_LO;
            mode_cur   <= 2'd0;
            pend       <= 1'b0;
            pend_mode  <= 2'd0;
            dir        <= DIR_UP;
            step_pulse <= 1'b0;
            wrap_pulse <= 1'b0;
        end else begin
            step_pulse <= tick;
            wrap_pulse <= 1'b0;
            if (!pause) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            end
            if (tick) begin
                if (pend) begin
                    mode_cur   <= pend_mode;
                    led_out    <= init_pat(pend_mode);
                    dir        <= DIR_UP;
                    pend       <= 1'b0;
                    wrap_pulse <= 1'b1;
                end else begin
                    led_out    <= nxt_led;
                    dir        <= nxt_dir;
                    wrap_pulse <= (nxt_led == init_pat(mode_cur));
                end
            end
            // A strobe on the tick edge is queued behind the value applied now.
            if (mode_load) begin
                pend      <= 1'b1;
                pend_mode <= mode_sel;
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomized bench for led_pattern_gen against a step-index reference model.
module tb_led_pattern_gen;

    localparam int N  = 8;
    localparam int CM = 3;
    localparam int CW = 2;

    logic         sys_clk   = 1'b0;
    logic         sys_rst_n = 1'b0;
    logic [1:0]   mode_sel  = 2'd0;
    logic         mode_load = 1'b0;
    logic         pause     = 1'b0;
    logic [N-1:0] led_out;
    logic [1:0]   mode_cur;
    logic         step_pulse;
    logic         wrap_pulse;

    led_pattern_gen #(
        .LED_NUM(N),
        .CNT_MAX(CM),
        .CNT_W  (CW)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .mode_sel  (mode_sel),
        .mode_load (mode_load),
        .pause     (pause),
        .led_out   (led_out),
        .mode_cur  (mode_cur),
        .step_pulse(step_pulse),
        .wrap_pulse(wrap_pulse)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: prescaler value, active mode, steps taken since mode start.
    int m_cnt, m_mode, m_k, m_pend, m_pmode;
    bit m_step, m_wrap;

    function automatic int period(input int m);
        return (m == 2) ? 2 * N - 2 : N;
    endfunction

    function automatic logic [N-1:0] pat(input int m, input int k);
        logic [N-1:0] r;
        int p;
        r = '0;
        case (m)
            0: r[k % N] = 1'b1;
            1: r[N - 1 - (k % N)] = 1'b1;
            2: begin
                p = k % (2 * N - 2);
                r[(p < N) ? p : (2 * N - 2 - p)] = 1'b1;
            end
            default: for (int i = 0; i <= k % N; i++) r[i] = 1'b1;
        endcase
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t",
                      tag, obs, exp, $time);
    endtask

    task automatic check_all();
        chk("led_out", 32'(led_out), 32'(pat(m_mode, m_k)));
        chk("mode_cur", 32'(mode_cur), 32'(m_mode));
        chk("step_pulse", 32'(step_pulse), 32'(m_step));
        chk("wrap_pulse", 32'(wrap_pulse), 32'(m_wrap));
        chk("led_nonzero", 32'(led_out != '0), 32'd1);
    endtask

    task automatic model_reset();
        m_cnt   = 0;
        m_mode  = 0;
        m_k     = 0;
        m_pend  = 0;
        m_pmode = 0;
        m_step  = 0;
        m_wrap  = 0;
    endtask

    // One clock: drive inputs, advance model at the edge, compare at negedge.
    task automatic step_cyc(input bit ld, input int ms, input bit ps);
        bit t;
        mode_load = ld;
        mode_sel  = 2'(ms);
        pause     = ps;
        @(posedge sys_clk);
        t      = (m_cnt == CM) && !ps;
        m_step = t;
        m_wrap = 0;
        if (t) begin
            if (m_pend != 0) begin
                m_mode = m_pmode;
                m_k    = 0;
                m_pend = 0;
                m_wrap = 1;
            end else begin
                m_k    = (m_k + 1) % period(m_mode);
                m_wrap = (m_k == 0);
            end
        end
        if (!ps) m_cnt = (m_cnt == CM) ? 0 : m_cnt + 1;
        if (ld) begin
            m_pend  = 1;
            m_pmode = ms;
        end
        @(negedge sys_clk);
        mode_load = 1'b0;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step_cyc(0, 0, 0);
    endtask

    initial begin
        int guard;
        model_reset();
        @(negedge sys_clk);
        check_all();
        sys_rst_n = 1'b1;

        // Mode 0 through a full rotation and wrap.
        run(40);
        // Ping-pong: more than one full period.
        step_cyc(1, 2, 0);
        run(64);
        // Fill bar, then switch to right-rotate.
        step_cyc(1, 3, 0);
        run(40);
        step_cyc(1, 1, 0);
        run(8);
        // Pause mid-period for ten cycles.
        run(2);
        for (int i = 0; i < 10; i++) step_cyc(0, 0, 1);
        run(10);
        // Two loads within one period: the last wins.
        step_cyc(1, 2, 0);
        step_cyc(1, 3, 0);
        run(8);
        // Load on the tick edge is applied one tick later.
        step_cyc(1, 0, 0);
        guard = 0;
        while (m_cnt != CM && guard < 16) begin
            step_cyc(0, 0, 0);
            guard++;
        end
        chk("tick_align_bound", 32'(guard < 16), 32'd1);
        step_cyc(1, 1, 0);
        run(9);
        // Reload of the active mode restarts it.
        run(6);
        step_cyc(1, m_mode, 0);
        run(6);
        // Load captured during pause.
        for (int i = 0; i < 6; i++) step_cyc(i == 2, 2, 1);
        run(8);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            step_cyc($urandom_range(0, 15) == 0, int'($urandom_range(0, 3)),
                     $urandom_range(0, 6) == 0);
        end

        // Reset mid-pattern in ping-pong while travelling down.
        step_cyc(1, 2, 0);
        run(40);
        #2;
        sys_rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        run(40);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
